// File: rtl/joy_db15_tx.sv
// DB15 adapter emulation: answers the reader's LOAD/CLK strobes and shifts
// {joystick2, joystick1} out LSB first on an active-low, idle-high DATA line.
module joy_db15_tx #(
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        joy_data,
    output logic        frame_done,
    output logic        overrun,
    output logic [5:0]  bit_index,
    output logic [1:0]  dbg_state
);

    localparam logic [5:0] LP_END_IDX = 6'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_clk_hist;

    state_t                 r_state;
    logic [FRAME_BITS-1:0]  r_sreg;
    logic [5:0]             r_idx;
    logic                   r_data;
    logic                   r_done;
    logic                   r_ovr;

    state_t                 w_state_nxt;
    logic [FRAME_BITS-1:0]  w_sreg_nxt;
    logic [5:0]             w_idx_nxt;
    logic                   w_data_nxt;
    logic                   w_done_nxt;
    logic                   w_ovr_nxt;
    logic                   w_clk_rise;
    logic                   w_load_low;

    // Synchronizers reset to 1 so a line held at either level through reset
    // cannot look like an edge afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_sync  <= '1;
            r_load_sync <= '1;
            r_clk_hist  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], joy_clk};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], joy_load};
            r_clk_hist  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_clk_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_hist;
    assign w_load_low = ~r_load_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_ovr_nxt   = r_ovr;
        // A load sample overrides any clock edge seen in the same cycle.
        if (w_load_low) begin
            w_state_nxt = ST_LOAD;
            w_sreg_nxt  = FRAME_BITS'({joystick2, joystick1});
            w_idx_nxt   = 6'd0;
            w_ovr_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: w_state_nxt = ST_SHIFT;
                ST_SHIFT: begin
                    if (w_clk_rise) begin
                        w_sreg_nxt = r_sreg >> 1;
                        w_idx_nxt  = r_idx + 6'd1;
                        if (r_idx == LP_END_IDX - 6'd1) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_clk_rise) begin
                        w_ovr_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        w_data_nxt = (w_idx_nxt < LP_END_IDX) ? ~w_sreg_nxt[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_idx   <= LP_END_IDX;
            r_data  <= 1'b1;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign joy_data   = r_data;
    assign frame_done = r_done;
    assign overrun    = r_ovr;
    assign bit_index  = r_idx;
    assign dbg_state  = r_state;

endmodule
